fir_sum_sat: RTL and testbench
==============================

# fir_sum_sat

Parametrised, fully pipelined FIR output combiner. It accepts NUM_MAC signed MAC partial sums, adds or subtracts each one per a compile-time mask, and optionally scales the result by a rounded arithmetic right shift. It saturates the result to OUT_W bits and registers it as the filter output. It sits after the MAC banks and drives the filter output port. Beyond a plain sum-and-clip it adds a registered adder tree, a valid pipeline, sticky overflow flags and a saturation event counter.

## Interface
- NUM_MAC, 4: number of MAC partial-sum lanes (1..16).
- IN_W, 16: width of each signed lane.
- OUT_W, 16: signed output width (OUT_W ≤ IN_W + clog2(NUM_MAC) + 1).
- SUB_MASK, 0: bit k=1 means lane k is subtracted; bit k=0 means it is added.
- SHIFT, 0: arithmetic right shift with round-half-up, applied before saturation (0..8).
- iClk_12M  in  1  system clock. One clock domain.
- iRsn  in  1  asynchronous active-low reset.
- iMac  in  NUM_MAC*IN_W  packed signed lanes; lane k = iMac[k*IN_W +: IN_W].
- iEnSample_600k  in  1  sample strobe.
- iEnDelay  in  1  delay-line-ready qualifier. A sample is accepted only when both strobes are 1.
- iSatClr  in  1  synchronous clear of sticky flags and the counter.
- oFirOut  out  OUT_W  saturated filter output. Holds its value between samples.
- oValid  out  1  one-cycle pulse when oFirOut updates.
- oSatPos  out  1  sticky flag: positive clip has occurred.
- oSatNeg  out  1  sticky flag: negative clip has occurred.
- oSatCnt  out  16  count of clipped samples.

## Operation
- Internal full-precision width: ACC_W = IN_W + clog2(NUM_MAC) + 1. The extra bit covers negation of the most negative input.
- Stage C (capture): when iEnSample_600k & iEnDelay, each lane is sign-extended to ACC_W, negated if its SUB_MASK bit is set, and registered. The valid bit is set.
- Stage T (tree): clog2(NUM_MAC) registered pairwise-add levels.
  - An odd lane passes through a level registered, unchanged.
  - Valid advances with the data.
- Stage S (scale/saturate/output):
  - r = (sum + (SHIFT ? 2^(SHIFT-1) : 0)) >>> SHIFT.
  - If r > 2^(OUT_W-1)-1, output 0x7FF…F and raise a positive clip event.
  - If r < -2^(OUT_W-1), output 0x80…0 and raise a negative clip event.
  - Otherwise output r truncated to OUT_W.
  - oFirOut is registered and oValid pulses for the same cycle.
- The pipeline has no backpressure and accepts a sample every cycle. Samples leave in acceptance order.
- Cycles without a valid sample do not change oFirOut, the flags or the counter.
- Sticky flags:
  - A clip event sets its flag.
  - iSatClr clears both flags.
  - If a set and iSatClr occur in the same cycle, the set wins (the flag ends at 1).
- oSatCnt:
  - Increments by 1 per clipped sample and holds at 0xFFFF.
  - iSatClr loads 0, or loads 1 if a clip event occurs in the same cycle.
- Reset (asynchronous, at any time):
  - All pipeline data and valid bits go to 0. In-flight samples are discarded and produce no oValid after reset release.
  - oFirOut=0, oValid=0, oSatPos=0, oSatNeg=0, oSatCnt=0.

## Timing
- Latency: L = clog2(NUM_MAC) + 2 cycles from the accepting edge to the oValid edge.
  - NUM_MAC=4: L=4.
  - NUM_MAC=1: L=2.
- Throughput: 1 sample per cycle.
- oSatPos, oSatNeg and oSatCnt update on the same edge as the corresponding oValid.
- The first clock edge after iRsn deasserts may accept a sample.

## Configuration
- FIR_SUM_SATCNT_EN defined: the 16-bit saturation counter is built as described.
- FIR_SUM_SATCNT_EN undefined: no counter is built and oSatCnt is tied to 0. Sticky flags and all other behaviour are unchanged.

## Structure
- Shared package fir_pkg holds:
  - the clog2 function;
  - ACC_W derivation;
  - the OUT_W saturation bound constants (max/min as functions of width);
  - the default MAC lane count and lane width.
- One sub-module, fir_add_level: one registered pairwise-add level with valid pass-through. It is instantiated clog2(NUM_MAC) times via generate.
- Capture, scale/saturate and flag/counter logic stay in the top.

## Test plan
- Defaults, lanes 1000/2000/3000/4000, both strobes high for one cycle → oFirOut=0x2710 and oValid pulse exactly 4 cycles later; flags stay 0.
- All four lanes 0x7000 → oFirOut=0x7FFF, oSatPos=1, oSatCnt=1. Then all four lanes 0x9000 → oFirOut=0x8000, oSatNeg=1, oSatCnt=2. Then iSatClr → flags 0, counter 0.
- SUB_MASK=4'b0010, lane1=0x8000, other lanes 0 → +32768 clips to 0x7FFF with oSatPos=1. This proves ACC_W headroom.
- SHIFT=2, lanes {7,0,0,0} → oFirOut=2. Lanes {-7,0,0,0} → oFirOut=-2 (0xFFFE).
- Eight back-to-back samples, with iEnDelay=0 on the 4th → seven oValid pulses in order with the 4th value absent. Also: iSatClr coincident with a clip → flag=1, counter=1.
- iRsn asserted while 3 samples are in flight → all outputs 0 immediately and no oValid after release. Also: with FIR_SUM_SATCNT_EN undefined, oSatCnt=0 after clips.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and elaboration-time helpers for the FIR output combiner.
// Used by fir_sum_sat (build option FIR_SUM_SATCNT_EN) and fir_add_level.
package fir_pkg;

  localparam int DEF_NUM_MAC = 4;
  localparam int DEF_IN_W    = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // One extra bit beyond the tree growth so that negating the most negative lane fits.
  function automatic int accWidth(input int inW, input int numMac);
    return inW + clog2(numMac) + 1;
  endfunction

  function automatic longint satMax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint satMin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic int laneCount(input int numMac, input int level);
    int n;
    n = numMac;
    for (int i = 0; i < level; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Lane offset of a tree level inside the flattened level bus.
  function automatic int laneOffset(input int numMac, input int level);
    int off;
    int n;
    off = 0;
    n   = numMac;
    for (int i = 0; i < level; i++) begin
      off = off + n;
      n   = (n + 1) / 2;
    end
    return off;
  endfunction

endpackage

// File: rtl/fir_add_level.sv
// One registered pairwise-add level of the combiner tree; an odd last lane
// passes through registered. Data is only reloaded when iValid is high.
module fir_add_level #(
  parameter int  NUM_IN  = 2,
  parameter int  W       = 18,
  localparam int NUM_OUT = (NUM_IN + 1) / 2
) (
  input  logic                 iClk_12M,
  input  logic                 iRsn,
  input  logic                 iValid,
  input  logic [NUM_IN*W-1:0]  iData,
  output logic                 oValid,
  output logic [NUM_OUT*W-1:0] oData
);

  logic [NUM_OUT*W-1:0] sumNext;

  for (genvar k = 0; k < NUM_OUT; k++) begin : gPair
    if (2 * k + 1 < NUM_IN) begin : gAdd
      assign sumNext[k*W +: W] = iData[(2*k)*W +: W] + iData[(2*k+1)*W +: W];
    end else begin : gPass
      assign sumNext[k*W +: W] = iData[(2*k)*W +: W];
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oValid <= 1'b0;
      oData  <= '0;
    end else begin
      oValid <= iValid;
      if (iValid) oData <= sumNext;
    end
  end

endmodule

// File: rtl/fir_sum_sat.sv
// Pipelined FIR output combiner: capture, adder tree, rounded shift, saturate.
// Build option FIR_SUM_SATCNT_EN adds the 16-bit saturation event counter.
module fir_sum_sat
  import fir_pkg::*;
#(
  parameter int                 NUM_MAC  = DEF_NUM_MAC,
  parameter int                 IN_W     = DEF_IN_W,
  parameter int                 OUT_W    = 16,
  parameter logic [NUM_MAC-1:0] SUB_MASK = '0,
  parameter int                 SHIFT    = 0
) (
  input  logic                    iClk_12M,
  input  logic                    iRsn,
  input  logic [NUM_MAC*IN_W-1:0] iMac,
  input  logic                    iEnSample_600k,
  input  logic                    iEnDelay,
  input  logic                    iSatClr,
  output logic [OUT_W-1:0]        oFirOut,
  output logic                    oValid,
  output logic                    oSatPos,
  output logic                    oSatNeg,
  output logic [15:0]             oSatCnt
);

  // Sample handshake: a sample is taken on every edge where iEnSample_600k and
  // iEnDelay are both high; there is no ready and the pipeline never stalls.
  // oValid is high for exactly one cycle per sample, with oFirOut valid in it.

  localparam int LEVELS      = clog2(NUM_MAC);
  localparam int ACC_W       = accWidth(IN_W, NUM_MAC);
  localparam int RND_W       = ACC_W + 1;
  localparam int TOTAL_LANES = laneOffset(NUM_MAC, LEVELS + 1);
  localparam int FINAL_OFF   = laneOffset(NUM_MAC, LEVELS) * ACC_W;

  localparam logic signed [RND_W-1:0] MAX_V = RND_W'(satMax(OUT_W));
  localparam logic signed [RND_W-1:0] MIN_V = RND_W'(satMin(OUT_W));
  localparam logic signed [RND_W-1:0] HALF  =
    (SHIFT > 0) ? RND_W'(64'sd1 <<< (SHIFT - 1)) : '0;

  logic                       accept;
  logic [NUM_MAC*ACC_W-1:0]   capNext;
  logic [NUM_MAC*ACC_W-1:0]   capData;
  logic                       capValid;
  logic [TOTAL_LANES*ACC_W-1:0] treeBus;
  logic [LEVELS:0]            treeValid;
  logic signed [ACC_W-1:0]    finalSum;
  logic signed [RND_W-1:0]    sumExt;
  logic signed [RND_W-1:0]    scaled;
  logic signed [RND_W-1:0]    s1Data;
  logic                       s1Valid;
  logic                       posClip;
  logic                       negClip;
  logic [OUT_W-1:0]           satOut;

  assign accept = iEnSample_600k & iEnDelay;

  // Stage C: sign-extend to full precision and apply the add/subtract mask.
  for (genvar k = 0; k < NUM_MAC; k++) begin : gLane
    logic signed [ACC_W-1:0] laneExt;
    assign laneExt = ACC_W'($signed(iMac[k*IN_W +: IN_W]));
    assign capNext[k*ACC_W +: ACC_W] = SUB_MASK[k] ? -laneExt : laneExt;
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      capData  <= '0;
      capValid <= 1'b0;
    end else begin
      capValid <= accept;
      if (accept) capData <= capNext;
    end
  end

  // Stage T: level l reads its lanes from treeBus and writes level l+1's lanes.
  assign treeBus[0 +: NUM_MAC*ACC_W] = capData;
  assign treeValid[0]                = capValid;

  for (genvar l = 0; l < LEVELS; l++) begin : gLevel
    localparam int NIN     = laneCount(NUM_MAC, l);
    localparam int NOUT    = laneCount(NUM_MAC, l + 1);
    localparam int IN_OFF  = laneOffset(NUM_MAC, l) * ACC_W;
    localparam int OUT_OFF = laneOffset(NUM_MAC, l + 1) * ACC_W;

    fir_add_level #(
      .NUM_IN (NIN),
      .W      (ACC_W)
    ) uLevel (
      .iClk_12M (iClk_12M),
      .iRsn     (iRsn),
      .iValid   (treeValid[l]),
      .iData    (treeBus[IN_OFF +: NIN*ACC_W]),
      .oValid   (treeValid[l+1]),
      .oData    (treeBus[OUT_OFF +: NOUT*ACC_W])
    );
  end

  assign finalSum = treeBus[FINAL_OFF +: ACC_W];

  // Stage S1: round-half-up arithmetic shift, one spare bit for the rounding add.
  assign sumExt = RND_W'(finalSum);
  assign scaled = (sumExt + HALF) >>> SHIFT;

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      s1Data  <= '0;
      s1Valid <= 1'b0;
    end else begin
      s1Valid <= treeValid[LEVELS];
      if (treeValid[LEVELS]) s1Data <= scaled;
    end
  end

  // Stage S2: saturate and register the output together with the flags.
  assign posClip = s1Valid && (s1Data > MAX_V);
  assign negClip = s1Valid && (s1Data < MIN_V);

  always_comb begin
    satOut = s1Data[OUT_W-1:0];
    if (s1Data > MAX_V) satOut = MAX_V[OUT_W-1:0];
    else if (s1Data < MIN_V) satOut = MIN_V[OUT_W-1:0];
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oFirOut <= '0;
      oValid  <= 1'b0;
      oSatPos <= 1'b0;
      oSatNeg <= 1'b0;
    end else begin
      oValid <= s1Valid;
      if (s1Valid) oFirOut <= satOut;
      // A clip in the same cycle as iSatClr leaves the flag set.
      oSatPos <= posClip | (oSatPos & ~iSatClr);
      oSatNeg <= negClip | (oSatNeg & ~iSatClr);
    end
  end

`ifdef FIR_SUM_SATCNT_EN
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oSatCnt <= '0;
    end else if (iSatClr) begin
      oSatCnt <= {15'd0, posClip | negClip};
    end else if ((posClip | negClip) && (oSatCnt != 16'hFFFF)) begin
      oSatCnt <= oSatCnt + 16'd1;
    end
  end
`else
  assign oSatCnt = '0;
`endif

endmodule

// File: tb/tb_fir_sum_sat.sv
// Bench for fir_sum_sat: three parameterisations driven with the same stimulus,
// checked against an arithmetic reference model and directed expectations.
module tb_fir_sum_sat;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int L    = 4;
  localparam int NDUT = 3;

  logic          iClk_12M = 1'b0;
  logic          iRsn;
  logic [N*W-1:0] iMac;
  logic          iEnSample_600k;
  logic          iEnDelay;
  logic          iSatClr;

  logic [15:0] firOut [NDUT];
  logic        valid  [NDUT];
  logic        satPos [NDUT];
  logic        satNeg [NDUT];
  logic [15:0] satCnt [NDUT];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- clock / reset ----------------
  always #5 iClk_12M = ~iClk_12M;

  fir_sum_sat #(.NUM_MAC(4), .IN_W(16), .OUT_W(16), .SUB_MASK(4'b0000), .SHIFT(0)) dut0 (
    .iClk_12M(iClk_12M), .iRsn(iRsn), .iMac(iMac), .iEnSample_600k(iEnSample_600k),
    .iEnDelay(iEnDelay), .iSatClr(iSatClr), .oFirOut(firOut[0]), .oValid(valid[0]),
    .oSatPos(satPos[0]), .oSatNeg(satNeg[0]), .oSatCnt(satCnt[0]));

  fir_sum_sat #(.NUM_MAC(4), .IN_W(16), .OUT_W(16), .SUB_MASK(4'b0010), .SHIFT(0)) dut1 (
    .iClk_12M(iClk_12M), .iRsn(iRsn), .iMac(iMac), .iEnSample_600k(iEnSample_600k),
    .iEnDelay(iEnDelay), .iSatClr(iSatClr), .oFirOut(firOut[1]), .oValid(valid[1]),
    .oSatPos(satPos[1]), .oSatNeg(satNeg[1]), .oSatCnt(satCnt[1]));

  fir_sum_sat #(.NUM_MAC(4), .IN_W(16), .OUT_W(16), .SUB_MASK(4'b0000), .SHIFT(2)) dut2 (
    .iClk_12M(iClk_12M), .iRsn(iRsn), .iMac(iMac), .iEnSample_600k(iEnSample_600k),
    .iEnDelay(iEnDelay), .iSatClr(iSatClr), .oFirOut(firOut[2]), .oValid(valid[2]),
    .oSatPos(satPos[2]), .oSatNeg(satNeg[2]), .oSatCnt(satCnt[2]));

  function automatic logic [3:0] maskOf(input int i);
    return (i == 1) ? 4'b0010 : 4'b0000;
  endfunction

  function automatic int shiftOf(input int i);
    return (i == 2) ? 2 : 0;
  endfunction

  function automatic logic [63:0] pack4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference: {negClip, posClip, out[15:0]} from plain signed arithmetic.
  function automatic logic [17:0] refModel(input logic [63:0] mac, input logic [3:0] mask,
                                           input int sh);
    longint s;
    longint r;
    longint v;
    s = 0;
    for (int k = 0; k < N; k++) begin
      v = longint'($signed(mac[k*W +: W]));
      s = mask[k] ? s - v : s + v;
    end
    r = s;
    if (sh > 0) r = (s + (64'sd1 <<< (sh - 1))) >>> sh;
    if (r > 32767)       return {2'b01, 16'h7FFF};
    else if (r < -32768) return {2'b10, 16'h8000};
    else                 return {2'b00, r[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic put(input logic [63:0] mac, input logic enS, input logic enD, input logic clr);
    iMac           = mac;
    iEnSample_600k = enS;
    iEnDelay       = enD;
    iSatClr        = clr;
    @(posedge iClk_12M);
    #1;
    iEnSample_600k = 1'b0;
    iEnDelay       = 1'b0;
    iSatClr        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iClk_12M);
      #1;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q    [NDUT][$];
  int          expCyc_q [NDUT][$];

  always @(posedge iClk_12M) begin
    cyc <= cyc + 1;
    if (iRsn && iEnSample_600k && iEnDelay) begin
      for (int i = 0; i < NDUT; i++) begin
        exp_q[i].push_back(refModel(iMac, maskOf(i), shiftOf(i)));
        expCyc_q[i].push_back(cyc + 1 + L);
      end
    end
  end

  logic        mPos [NDUT];
  logic        mNeg [NDUT];
  logic [15:0] mCnt [NDUT];
  logic [15:0] mOut [NDUT];
  logic        clrSeen = 1'b0;
  logic [17:0] e;
  logic [1:0]  clip;
  int          ec;
  int          validCnt0 = 0;

  always @(negedge iClk_12M) begin
    for (int i = 0; i < NDUT; i++) begin
      if (!iRsn) begin
        exp_q[i].delete();
        expCyc_q[i].delete();
        mPos[i] = 1'b0;
        mNeg[i] = 1'b0;
        mCnt[i] = '0;
        mOut[i] = '0;
        chk($sformatf("rst_out%0d", i), firOut[i], 16'h0);
        chk($sformatf("rst_valid%0d", i), valid[i], 1'b0);
      end else begin
        clip = 2'b00;
        if (valid[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("spurious_valid%0d", i), valid[i], 1'b0);
          end else begin
            e  = exp_q[i].pop_front();
            ec = expCyc_q[i].pop_front();
            chk($sformatf("latency%0d", i), cyc, ec);
            clip    = e[17:16];
            mOut[i] = e[15:0];
            if (i == 0) validCnt0++;
          end
        end else if (expCyc_q[i].size() > 0 && expCyc_q[i][0] <= cyc) begin
          chk($sformatf("missing_valid%0d", i), valid[i], 1'b1);
          void'(exp_q[i].pop_front());
          void'(expCyc_q[i].pop_front());
        end
        mPos[i] = clip[0] | (mPos[i] & ~clrSeen);
        mNeg[i] = clip[1] | (mNeg[i] & ~clrSeen);
`ifdef FIR_SUM_SATCNT_EN
        if (clrSeen) mCnt[i] = {15'd0, |clip};
        else if ((|clip) && mCnt[i] != 16'hFFFF) mCnt[i] = mCnt[i] + 16'd1;
`endif
        chk($sformatf("out%0d", i), firOut[i], mOut[i]);
        chk($sformatf("pos%0d", i), satPos[i], mPos[i]);
        chk($sformatf("neg%0d", i), satNeg[i], mNeg[i]);
        chk($sformatf("cnt%0d", i), satCnt[i], mCnt[i]);
      end
    end
    clrSeen = iSatClr;
  end

  // ---------------- directed sequence ----------------
  logic [15:0] cntAfter1;
  logic [15:0] cntAfter2;
  int          snap;

  initial begin
`ifdef FIR_SUM_SATCNT_EN
    cntAfter1 = 16'd1;
    cntAfter2 = 16'd2;
`else
    cntAfter1 = 16'd0;
    cntAfter2 = 16'd0;
`endif
    iRsn = 1'b0; iMac = '0; iEnSample_600k = 1'b0; iEnDelay = 1'b0; iSatClr = 1'b0;
    idle(3);
    chk("reset_out", firOut[0], 16'h0);
    chk("reset_valid", valid[0], 1'b0);
    chk("reset_pos", satPos[0], 1'b0);
    chk("reset_neg", satNeg[0], 1'b0);
    chk("reset_cnt", satCnt[0], 16'h0);
    iRsn = 1'b1;

    // plain sum and exact latency
    put(pack4(16'd1000, 16'd2000, 16'd3000, 16'd4000), 1, 1, 0);
    idle(3);
    chk("lat_not_yet", valid[0], 1'b0);
    idle(1);
    chk("lat_valid", valid[0], 1'b1);
    chk("sum_2710", firOut[0], 16'h2710);
    chk("sum_pos0", satPos[0], 1'b0);
    chk("sum_neg0", satNeg[0], 1'b0);
    idle(1);
    chk("valid_one_cycle", valid[0], 1'b0);
    chk("out_holds", firOut[0], 16'h2710);

    // positive then negative clip, then clear
    put(pack4(16'h7000, 16'h7000, 16'h7000, 16'h7000), 1, 1, 0);
    idle(5);
    chk("clip_pos_out", firOut[0], 16'h7FFF);
    chk("clip_pos_flag", satPos[0], 1'b1);
    chk("clip_pos_cnt", satCnt[0], cntAfter1);
    put(pack4(16'h9000, 16'h9000, 16'h9000, 16'h9000), 1, 1, 0);
    idle(5);
    chk("clip_neg_out", firOut[0], 16'h8000);
    chk("clip_neg_flag", satNeg[0], 1'b1);
    chk("clip_neg_cnt", satCnt[0], cntAfter2);
    put('0, 0, 0, 1);
    chk("clr_pos", satPos[0], 1'b0);
    chk("clr_neg", satNeg[0], 1'b0);
    chk("clr_cnt", satCnt[0], 16'h0);

    // subtract mask headroom: -(-32768) must clip positive, not wrap
    put(pack4(16'h0, 16'h8000, 16'h0, 16'h0), 1, 1, 0);
    idle(5);
    chk("mask_out", firOut[1], 16'h7FFF);
    chk("mask_pos", satPos[1], 1'b1);
    chk("mask_plain_min", firOut[0], 16'h8000);
    chk("mask_plain_noclip", satNeg[0], 1'b0);
    chk("mask_shift", firOut[2], 16'hE000);

    // rounded shift
    put(pack4(16'd7, 16'h0, 16'h0, 16'h0), 1, 1, 0);
    idle(5);
    chk("shift_p7", firOut[2], 16'd2);
    put(pack4(-16'sd7, 16'h0, 16'h0, 16'h0), 1, 1, 0);
    idle(5);
    chk("shift_m7", firOut[2], 16'hFFFE);
    put(pack4(-16'sd6, 16'h0, 16'h0, 16'h0), 1, 1, 0);
    idle(5);
    chk("shift_m6", firOut[2], 16'hFFFF);

    // back-to-back with one sample refused by iEnDelay
    snap = validCnt0;
    for (int j = 0; j < 8; j++) put({$urandom, $urandom}, 1, (j != 3), 0);
    idle(6);
    chk("b2b_count", validCnt0 - snap, 7);

    // clear coincident with a clip: set wins
    put('0, 0, 0, 1);
    put(pack4(16'h7000, 16'h7000, 16'h7000, 16'h7000), 1, 1, 0);
    idle(3);
    put('0, 0, 0, 1);
    chk("clr_vs_set_valid", valid[0], 1'b1);
    chk("clr_vs_set_flag", satPos[0], 1'b1);
    chk("clr_vs_set_cnt", satCnt[0], cntAfter1);

    // random traffic
    for (int j = 0; j < 300; j++) begin
      put({$urandom, $urandom}, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) == 0));
    end
    idle(8);

    // reset with samples in flight
    put(pack4(16'h7000, 16'h7000, 16'h7000, 16'h7000), 1, 1, 0);
    put(pack4(16'h9000, 16'h9000, 16'h9000, 16'h9000), 1, 1, 0);
    put(pack4(16'd5, 16'd6, 16'd7, 16'd8), 1, 1, 0);
    snap = validCnt0;
    iRsn = 1'b0;
    #1;
    chk("async_out", firOut[0], 16'h0);
    chk("async_valid", valid[0], 1'b0);
    chk("async_pos", satPos[0], 1'b0);
    chk("async_neg", satNeg[0], 1'b0);
    chk("async_cnt", satCnt[0], 16'h0);
    idle(2);
    iRsn = 1'b1;
    idle(8);
    chk("no_valid_after_rst", validCnt0 - snap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
